// File: rtl/msd_pkg.sv
// msd_pkg: shared command, operation and state encodings, address fields and DDR5 timing defaults
package msd_pkg;
  typedef enum logic [2:0] {ACT0 = 3'd0, ACT1, RD0, RD1, WR0, WR1, PRE} cmd_e;
  typedef enum logic [1:0] {READ = 2'd0, WRITE, IFETCH, ILLEGAL} oper_e;
  typedef enum logic [3:0] {
    S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
  } state_e;
  localparam int CHAN_BIT = 6;
  localparam int BG_LSB = 7;
  localparam int BANK_LSB = 10;
  localparam int COL_LSB = 12;
  localparam int ROW_LSB = 18;
  localparam int DEF_T_RCD = 39;
  localparam int DEF_T_RAS = 76;
  localparam int DEF_T_RP = 39;
  localparam int DEF_T_RTP = 18;
  localparam int DEF_T_CWL = 38;
  localparam int DEF_T_BURST = 8;
  localparam int DEF_T_WR = 30;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/msd_timing_cnt.sv
// msd_timing_cnt: saturating cycle counter that flags when it reaches threshold-1
module msd_timing_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] thr,
  output logic             reached
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst_n || clr) ? '0 : cnt + CNT_W'(!(&cnt));
  assign reached = cnt >= thr - 1'b1;
endmodule

// File: rtl/msd_cmd_sched.sv
// msd_cmd_sched: closed-page DDR5 scheduler issuing ACT, RD/WR and PRE at their earliest legal cycles
module msd_cmd_sched
  import msd_pkg::*;
#(
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_RP = DEF_T_RP,
  parameter int T_RTP = DEF_T_RTP,
  parameter int T_CWL = DEF_T_CWL,
  parameter int T_BURST = DEF_T_BURST,
  parameter int T_WR = DEF_T_WR,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [37:0] req_data,
  output logic        req_ready,
  output logic        cmd_valid,
  output cmd_e        cmd_op,
  output logic        cmd_chan,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [5:0]  cmd_col,
  output logic        busy,
  output logic        done,
  output logic        err_illegal
);
  state_e state, nxt;
  cmd_e nxt_op;
  logic [1:0] op_q;
  logic accept, is_wr, illegal, act_ok, cas_ok, rp_ok, issue, unused;
  assign unused = ^{req_data[35:34], req_data[5:0]};
  assign accept = req_valid && req_ready;
  assign illegal = req_data[37:36] == ILLEGAL;
  assign is_wr = op_q == WRITE;
  assign busy = state != S_IDLE;
  assign done = state == S_PRE;
  msd_timing_cnt #(.CNT_W(CNT_W)) u_act_cnt (
    .clk(clk), .rst_n(rst_n), .clr(nxt == S_ACT0),
    .thr(state inside {S_ACT1, S_WAIT_RCD} ? CNT_W'(T_RCD) : CNT_W'(T_RAS)),
    .reached(act_ok)
  );
  msd_timing_cnt #(.CNT_W(CNT_W)) u_cas_cnt (
    .clk(clk), .rst_n(rst_n), .clr(nxt == S_CAS0),
    .thr(is_wr ? CNT_W'(T_CWL + T_BURST + T_WR) : CNT_W'(T_RTP)),
    .reached(cas_ok)
  );
  msd_timing_cnt #(.CNT_W(CNT_W)) u_rp_cnt (
    .clk(clk), .rst_n(rst_n), .clr(nxt == S_PRE), .thr(CNT_W'(T_RP)), .reached(rp_ok)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = (accept && !illegal) ? S_ACT0 : S_IDLE;
      S_ACT0: nxt = S_ACT1;
      S_ACT1, S_WAIT_RCD: nxt = act_ok ? S_CAS0 : S_WAIT_RCD;
      S_CAS0: nxt = S_CAS1;
      S_CAS1, S_WAIT_PRE: nxt = (act_ok && cas_ok) ? S_PRE : S_WAIT_PRE;
      S_PRE: nxt = S_WAIT_RP;
      S_WAIT_RP: nxt = rp_ok ? S_IDLE : S_WAIT_RP;
      default: nxt = S_IDLE;
    endcase
  end
  assign issue = nxt inside {S_ACT0, S_ACT1, S_CAS0, S_CAS1, S_PRE};
  assign nxt_op = nxt == S_ACT0 ? ACT0 :
                  nxt == S_ACT1 ? ACT1 :
                  nxt == S_CAS0 ? (is_wr ? WR0 : RD0) :
                  nxt == S_CAS1 ? (is_wr ? WR1 : RD1) : PRE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      req_ready <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op <= ACT0;
      err_illegal <= 1'b0;
      op_q <= '0;
      cmd_chan <= 1'b0;
      cmd_bg <= '0;
      cmd_bank <= '0;
      cmd_row <= '0;
      cmd_col <= '0;
    end else begin
      state <= nxt;
      req_ready <= nxt == S_IDLE;
      cmd_valid <= issue;
      err_illegal <= accept && illegal;
      if (issue) cmd_op <= nxt_op;
      if (accept) begin
        op_q <= req_data[37:36];
        cmd_chan <= req_data[CHAN_BIT];
        cmd_bg <= req_data[BG_LSB +: 3];
        cmd_bank <= req_data[BANK_LSB +: 2];
        cmd_row <= req_data[ROW_LSB +: 16];
        cmd_col <= req_data[COL_LSB +: 6];
      end
    end
  end
endmodule

// File: tb/tb_msd_cmd_sched.sv
// tb_msd_cmd_sched: directed scoreboard bench for default and fast-timing schedulers
module tb_msd_cmd_sched;
  import msd_pkg::*;
  typedef struct packed {logic [31:0] cyc; logic [30:0] f;} exp_t;
  localparam int RCD = 39, RAS = 76, RP = 39, RTP = 18, WREC = 38 + 8 + 30;
  localparam logic [35:0] A = 36'h0_0003_C6C0, B = 36'h9_ABCD_1234, C = 36'h3_5F2E_9A40;
  logic clk = 1'b0, rst_n = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic [37:0] req_data = '0;
  logic rdy [2], cv [2], chan [2], busy_o [2], done_o [2], err [2];
  cmd_e op [2];
  logic [2:0] bg [2];
  logic [1:0] bank [2];
  logic [15:0] row [2];
  logic [5:0] col [2];
  int cyc = 0, vectors = 0, miss = 0;
  exp_t q0 [$], q1 [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  msd_cmd_sched u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_data(req_data), .req_ready(rdy[0]),
    .cmd_valid(cv[0]), .cmd_op(op[0]), .cmd_chan(chan[0]), .cmd_bg(bg[0]), .cmd_bank(bank[0]),
    .cmd_row(row[0]), .cmd_col(col[0]), .busy(busy_o[0]), .done(done_o[0]), .err_illegal(err[0])
  );
  msd_cmd_sched #(.T_RCD(2), .T_RAS(4), .T_RP(2), .T_RTP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_data(req_data), .req_ready(rdy[1]),
    .cmd_valid(cv[1]), .cmd_op(op[1]), .cmd_chan(chan[1]), .cmd_bg(bg[1]), .cmd_bank(bank[1]),
    .cmd_row(row[1]), .cmd_col(col[1]), .busy(busy_o[1]), .done(done_o[1]), .err_illegal(err[1])
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] outs(input int w);
    return {rdy[w], cv[w], op[w], chan[w], bg[w], bank[w], row[w], col[w], busy_o[w], done_o[w], err[w]};
  endfunction
  function automatic int push_seq(input int w, input int t0, input logic [1:0] opc,
                                  input logic [35:0] a, input int rcd, input int ras,
                                  input int rtp, input int rp);
    logic [27:0] fl;
    int cy [5];
    cmd_e ops [5];
    exp_t e;
    bit wr;
    fl = {a[6], a[9:7], a[11:10], a[33:18], a[17:12]};
    wr = opc == 2'd1;
    cy[0] = t0 + 1;
    cy[1] = t0 + 2;
    cy[2] = t0 + 1 + rcd;
    cy[3] = t0 + 2 + rcd;
    cy[4] = t0 + 1 + ras;
    if (cy[2] + (wr ? WREC : rtp) > cy[4]) cy[4] = cy[2] + (wr ? WREC : rtp);
    ops[0] = ACT0;
    ops[1] = ACT1;
    ops[2] = wr ? WR0 : RD0;
    ops[3] = wr ? WR1 : RD1;
    ops[4] = PRE;
    for (int k = 0; k < 5; k++) begin
      e = {32'(cy[k]), ops[k], fl};
      if (w == 0) q0.push_back(e); else q1.push_back(e);
    end
    return cy[4] + rp;
  endfunction
  task automatic mon(input int w);
    exp_t e;
    logic [30:0] got;
    int sz;
    got = {op[w], chan[w], bg[w], bank[w], row[w], col[w]};
    sz = w == 0 ? q0.size() : q1.size();
    check($sformatf("cmd_expected_u%0d_cyc%0d", w, cyc), 64'(sz != 0), 64'd1);
    if (sz != 0) begin
      if (w == 0) e = q0.pop_front(); else e = q1.pop_front();
      check($sformatf("cmd_u%0d_cyc%0d", w, e.cyc), {cyc, got, done_o[w]},
            {e.cyc, e.f, e.f[30:28] == PRE});
    end
  endtask
  always @(negedge clk) for (int w = 0; w < 2; w++) if (cv[w]) mon(w);
  task automatic do_req(input int w, input logic [1:0] opc, input logic [35:0] a, output int t0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rdy[w]) break;
    end
    check("req_ready_wait", 64'(rdy[w]), 64'd1);
    req_data = {opc, a};
    if (w == 0) v0 = 1'b1; else v1 = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask
  task automatic wait_idle(input int w, input int idle);
    for (int i = 0; i < 1000 && cyc < idle - 1; i++) @(negedge clk);
    check("ready_low_before_idle", 64'(rdy[w]), 64'd0);
    @(negedge clk);
    check("ready_at_idle", 64'({rdy[w], busy_o[w], 32'(cyc)}), 64'({2'b10, 32'(idle)}));
    check("queue_drained", 64'(w == 0 ? q0.size() : q1.size()), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    int t0, idle, hi;
    repeat (3) @(negedge clk);
    check("reset_u0", 64'(outs(0)), 64'd0);
    check("reset_u1", 64'(outs(1)), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'({rdy[0], rdy[1]}), 64'd3);
    do_req(0, 2'd0, A, t0);
    wait_idle(0, push_seq(0, t0, 2'd0, A, RCD, RAS, RTP, RP));
    do_req(0, 2'd1, B, t0);
    wait_idle(0, push_seq(0, t0, 2'd1, B, RCD, RAS, RTP, RP));
    do_req(0, 2'd2, A, t0);
    wait_idle(0, push_seq(0, t0, 2'd2, A, RCD, RAS, RTP, RP));
    do_req(0, 2'd3, C, t0);
    @(negedge clk);
    check("illegal_pulse", 64'({err[0], rdy[0], busy_o[0], cv[0]}), 64'b1100);
    @(negedge clk);
    check("illegal_after", 64'({err[0], rdy[0], busy_o[0], cv[0]}), 64'b0100);
    for (int i = 0; i < 400 && !rdy[0]; i++) @(negedge clk);
    req_data = {2'd0, A};
    v0 = 1'b1;
    t0 = cyc;
    idle = push_seq(0, t0, 2'd0, A, RCD, RAS, RTP, RP);
    @(posedge clk);
    #1;
    req_data = {2'd0, C};
    hi = 0;
    for (int i = 1; i <= 115; i++) begin
      @(negedge clk);
      hi += int'(rdy[0]);
    end
    check("ready_low_during_seq", 64'(hi), 64'd0);
    @(negedge clk);
    check("b2b_ready", 64'({rdy[0], 32'(cyc - t0)}), 64'({1'b1, 32'd116}));
    idle = push_seq(0, cyc, 2'd0, C, RCD, RAS, RTP, RP);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    wait_idle(0, idle);
    do_req(0, 2'd0, B, t0);
    idle = push_seq(0, t0, 2'd0, B, RCD, RAS, RTP, RP);
    for (int i = 0; i < 200 && cyc < t0 + 50; i++) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    @(negedge clk);
    check("midop_reset_outputs", 64'(outs(0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midop_reset", 64'({rdy[0], busy_o[0], cv[0]}), 64'b100);
    do_req(0, 2'd0, A, t0);
    wait_idle(0, push_seq(0, t0, 2'd0, A, RCD, RAS, RTP, RP));
    do_req(1, 2'd0, C, t0);
    wait_idle(1, push_seq(1, t0, 2'd0, C, 2, 4, 1, 2));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
